// File: rtl/div_repsub_pkg.sv
// Shared definitions for the repeated-subtraction divider: default width and
// controller state encodings.
package div_repsub_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage : div_repsub_pkg

// File: rtl/div_repsub_if.sv
// Operand/result bus of the divider. The master side issues start and the two
// operand words; the slave side returns quotient, remainder and status flags.
interface div_repsub_if
  import div_repsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, div_by_zero
  );

endinterface : div_repsub_if

// File: rtl/div_repsub_datapath.sv
// Divider datapath: remainder (R), quotient (Q) and divisor (B) registers,
// the R-B subtractor, the R>=B comparator and the B==0 detector. All register
// updates are steered by strobes from the controller in the top.
module div_repsub_datapath
  import div_repsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ld_r_i,     // R <= data_i
  input  logic             ld_b_i,     // B <= data_i
  input  logic             clr_q_i,    // Q <= 0, div_by_zero <= 0
  input  logic             sub_i,      // R <= R-B, Q <= Q+1
  input  logic             set_dbz_i,  // Q <= all-ones, div_by_zero <= 1
  output logic             geq_o,
  output logic             bz_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dbz_o
);

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             dbz_q, dbz_d;

  // Full-width unsigned compare; it also guards the subtraction against underflow.
  assign geq_o = (r_q >= b_q);
  assign bz_o  = (b_q == '0);

  // Next-state selection for the datapath registers from the controller strobes.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    r_d   = r_q;
    q_d   = q_q;
    b_d   = b_q;
    dbz_d = dbz_q;

    if (ld_r_i) begin
      r_d = data_i;
    end else if (sub_i) begin
      r_d = r_q - b_q;
    end

    if (ld_b_i) begin
      b_d = data_i;
    end

    if (clr_q_i) begin
      q_d   = '0;
      dbz_d = 1'b0;
    end else if (set_dbz_i) begin
      q_d   = '1;
      dbz_d = 1'b1;
    end else if (sub_i) begin
      q_d = q_q + 1'b1;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: these are plain registers, not a memory array, so clearing them on
    // reset is cheap and gives defined outputs straight after reset.
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_q   <= '0;
      q_q   <= '0;
      b_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      b_q   <= b_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient_o  = q_q;
  assign remainder_o = r_q;
  assign dbz_o       = dbz_q;

endmodule : div_repsub_datapath

// File: rtl/div_repsub.sv
// Unsigned repeated-subtraction divider. The controller FSM sequences
// start -> dividend -> divisor -> subtract loop -> done, driving the datapath
// through load/clear/subtract strobes. A held start parks the block in DONE;
// a new operation requires start to drop and rise again.
module div_repsub
  import div_repsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  div_repsub_if.slave  bus
);

  state_e state_q, state_d;

  logic ld_r, ld_b, clr_q, sub, set_dbz;
  logic geq, bz;

  div_repsub_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_i      (bus.data_in),
    .ld_r_i      (ld_r),
    .ld_b_i      (ld_b),
    .clr_q_i     (clr_q),
    .sub_i       (sub),
    .set_dbz_i   (set_dbz),
    .geq_o       (geq),
    .bz_o        (bz),
    .quotient_o  (bus.quotient),
    .remainder_o (bus.remainder),
    .dbz_o       (bus.div_by_zero)
  );

  // State register; reset overrides any state, including mid-RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobe decode.
  always_comb begin
    state_d = state_q;
    ld_r    = 1'b0;
    ld_b    = 1'b0;
    clr_q   = 1'b0;
    sub     = 1'b0;
    set_dbz = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        ld_r    = 1'b1;
        clr_q   = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        ld_b    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bz) begin
          set_dbz = 1'b1;
          state_d = S_DONE;
        end else if (geq) begin
          sub = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags decoded directly from the registered state.
  assign bus.done = (state_q == S_DONE);
  assign bus.busy = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_RUN);

endmodule : div_repsub
